// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Operand-resolution and interlock unit for the in-order
//               pipeline. Resolves NSRC source operands per cycle from NFWD
//               prioritised bypass sources, the register file, or the
//               constant x0, and tracks in-flight writes per register with
//               saturating pending counters (issue to commit).
// Ports       : clk, reset (async, active-low)
//               issue_*   : instruction presented by decode
//               rf_q      : register-file read data for issue_rs
//               issue_ready / opnd : combinational resolution result
//               fwd_*     : bypass sources, index 0 = youngest
//               commit_*  : write retiring to the register file
//               flush     : kill all uncommitted instructions
//               err       : sticky, commit to a register with nothing pending
//               stall_cnt : saturating count of stalled issue cycles
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int XLEN    = 64,
    parameter int NSRC    = 2,
    parameter int NFWD    = 3,
    parameter int MAXPEND = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic                 issue_regwrite,
    input  logic [4:0]           issue_rd,
    input  logic [NSRC*5-1:0]    issue_rs,
    input  logic [NSRC*XLEN-1:0] rf_q,
    output logic                 issue_ready,
    output logic [NSRC*XLEN-1:0] opnd,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD*5-1:0]    fwd_dst,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic [NFWD-1:0]      fwd_ready,
    input  logic                 commit_valid,
    input  logic [4:0]           commit_rd,
    input  logic                 flush,
    output logic                 err,
    output logic [31:0]          stall_cnt
);

    localparam int            CW        = $clog2(MAXPEND + 1);
    localparam logic [CW-1:0] C_MAXPEND = CW'(MAXPEND);

    // Entry 0 is held at zero so x0 never looks pending.
    logic [CW-1:0] r_pend [32];
    logic          r_err;
    logic [31:0]   r_stall_cnt;

    logic [NSRC-1:0] w_res;
    logic            w_sat;
    logic            w_fire;
    logic [31:1]     w_inc;
    logic [31:1]     w_dec;

    // ------------------------------------------------------------------
    // Per-source operand resolution
    // ------------------------------------------------------------------
    generate
        for (genvar s = 0; s < NSRC; s++) begin : g_src
            logic [4:0]      w_rs;
            logic            w_hit;
            logic            w_hit_rdy;
            logic [XLEN-1:0] w_hit_data;
            logic            w_res_s;
            logic [XLEN-1:0] w_opnd_s;

            assign w_rs = issue_rs[s*5 +: 5];

            // Scan from oldest to youngest so the lowest matching index
            // (youngest producer) is the one left standing.
            always_comb begin
                w_hit      = 1'b0;
                w_hit_rdy  = 1'b0;
                w_hit_data = '0;
                for (int i = NFWD - 1; i >= 0; i--) begin
                    if (fwd_valid[i] && (fwd_dst[i*5 +: 5] == w_rs) &&
                        (fwd_dst[i*5 +: 5] != 5'd0)) begin
                        w_hit      = 1'b1;
                        w_hit_rdy  = fwd_ready[i];
                        w_hit_data = fwd_data[i*XLEN +: XLEN];
                    end
                end
            end

            always_comb begin
                w_res_s  = 1'b1;
                w_opnd_s = '0;
                if (w_rs != 5'd0) begin
                    if (w_hit) begin
                        if (w_hit_rdy) begin
                            w_opnd_s = w_hit_data;
                        end else begin
                            w_res_s = 1'b0;
                        end
                    end else if (r_pend[w_rs] == '0) begin
                        w_opnd_s = rf_q[s*XLEN +: XLEN];
                    end else begin
                        // Write in flight in a unit with no bypass path.
                        w_res_s = 1'b0;
                    end
                end
            end

            assign w_res[s]               = w_res_s;
            assign opnd[s*XLEN +: XLEN]   = w_opnd_s;
        end
    endgenerate

    assign w_sat       = issue_regwrite && (issue_rd != 5'd0) &&
                         (r_pend[issue_rd] == C_MAXPEND);
    assign issue_ready = (&w_res) && !w_sat;
    assign w_fire      = issue_valid && issue_ready;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int r = 1; r < 32; r++) begin
            w_inc[r] = w_fire && issue_regwrite && (issue_rd == 5'(r));
            w_dec[r] = commit_valid && (commit_rd == 5'(r)) && (r_pend[r] != '0);
        end
    end

    // ------------------------------------------------------------------
    // Pending counters, sticky error, stall counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < 32; r++) begin
                r_pend[r] <= '0;
            end
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (issue_valid && !issue_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (flush) begin
                // Flush wins over same-cycle issue and commit; the error
                // check is skipped because the commit is being discarded.
                for (int r = 1; r < 32; r++) begin
                    r_pend[r] <= '0;
                end
            end else begin
                for (int r = 1; r < 32; r++) begin
                    if (w_inc[r] && !w_dec[r]) begin
                        r_pend[r] <= r_pend[r] + CW'(1);
                    end else if (w_dec[r] && !w_inc[r]) begin
                        r_pend[r] <= r_pend[r] - CW'(1);
                    end
                end
                if (commit_valid && (commit_rd != 5'd0) && (r_pend[commit_rd] == '0)) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign err       = r_err;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
